// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch front end.
// Holds the datapath width, the PC increment, the 2-bit branch counter
// encodings, the BTB entry layout and the counter saturation helpers.
// No ports (package).
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;
  localparam int CTR_W   = 2;

  // 2-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // The tag field is sized for the smallest legal BTB (two entries).
  // Larger tables store the shifted PC zero-extended in the same field.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  tag;
    logic [XLEN-1:0]  target;
    ctr_e             ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RST = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_WNT
  };

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   lk_pc_i              lookup PC (combinational, zero latency)
//   lk_hit_o             valid entry with matching tag
//   lk_taken_o           hit and counter predicts taken
//   lk_target_o          predicted target, 0 when not predicted taken
//   upd_we_i             resolved branch/jump: train the table
//   upd_pc_i             PC of the resolved branch/jump
//   upd_taken_i          resolved direction
//   upd_target_i         resolved taken target
// Lookup reads the registered array, so an update to the same index in
// the same cycle is only visible from the next cycle on.
module btb_dm
  import pipe_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            lk_hit_o,
  output logic            lk_taken_o,
  output logic [XLEN-1:0] lk_target_o,
  input  logic            upd_we_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int TAG_SH = IDX_W + 2;

  btb_entry_t mem_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [XLEN-1:0]  lk_tag;
  btb_entry_t       lk_ent;

  logic [IDX_W-1:0] u_idx;
  logic [XLEN-1:0]  u_tag;
  btb_entry_t       u_ent;
  logic             u_hit;
  logic             upd_wr;
  btb_entry_t       upd_entry_d;

  // Word alignment bits never take part in indexing or tagging.
  logic unused_align_bits;
  assign unused_align_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

  // ---------------- lookup ----------------
  assign lk_idx      = lk_pc_i[IDX_W+1:2];
  assign lk_tag      = lk_pc_i >> TAG_SH;
  assign lk_ent      = mem_q[lk_idx];
  assign lk_hit_o    = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign lk_taken_o  = lk_hit_o && lk_ent.ctr[1];
  assign lk_target_o = lk_taken_o ? lk_ent.target : '0;

  // ---------------- update ----------------
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i >> TAG_SH;
  assign u_ent = mem_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  always_comb begin
    upd_entry_d = u_ent;
    upd_wr      = 1'b0;
    if (upd_we_i) begin
      if (u_hit) begin
        upd_wr = 1'b1;
        if (upd_taken_i) begin
          upd_entry_d.ctr    = ctr_inc(u_ent.ctr);
          upd_entry_d.target = upd_target_i;
        end else begin
          upd_entry_d.ctr    = ctr_dec(u_ent.ctr);
        end
      end else if (upd_taken_i) begin
        // Taken miss allocates over whatever occupied the slot, starting
        // weakly taken so a single later not-taken flips the prediction.
        upd_wr      = 1'b1;
        upd_entry_d = '{valid: 1'b1, tag: u_tag, target: upd_target_i, ctr: CTR_WT};
      end
      // Not-taken miss leaves the table untouched.
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every field of every entry is reset, not only the valid bits,
      // so no X can leak from tag compare or target mux after reset.
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= BTB_ENTRY_RST;
      end
    end else if (upd_wr) begin
      mem_q[u_idx] <= upd_entry_d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage fetch PC unit: receives the branch-resolution interface from
// MEM, holds the fetch PC and chooses the next fetch address
// (redirect > stall > predicted-taken target > PC+4).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en               fetch enable, 0 stalls the PC
//   modify_pc_in     redirect request from MEM (overrides a stall)
//   update_pc_in     redirect address (low two bits forced to 0)
//   jump_addr_in     resolved taken target used to train the BTB
//   update_btb_in    resolved branch/jump in MEM, train the BTB
//   upd_src_pc_in    PC of the resolved branch/jump
//   upd_taken_in     resolved direction
//   pc_if            current fetch PC
//   pred_taken_if    BTB predicts taken for pc_if
//   pred_target_if   predicted target, 0 when not predicted taken
//   flush_front      kill IF/ID, equals modify_pc_in combinationally
module fetch_pc_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  localparam int         IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        modify_pc_in,
  input  logic [31:0] update_pc_in,
  input  logic [31:0] jump_addr_in,
  input  logic        update_btb_in,
  input  logic [31:0] upd_src_pc_in,
  input  logic        upd_taken_in,
  output logic [31:0] pc_if,
  output logic        pred_taken_if,
  output logic [31:0] pred_target_if,
  output logic        flush_front
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            btb_hit_unused;
  logic            unused_redirect_bits;

  assign unused_redirect_bits = ^update_pc_in[1:0];

  btb_dm #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lk_pc_i      (pc_q),
    .lk_hit_o     (btb_hit_unused),
    .lk_taken_o   (pred_taken_if),
    .lk_target_o  (pred_target_if),
    .upd_we_i     (update_btb_in),
    .upd_pc_i     (upd_src_pc_in),
    .upd_taken_i  (upd_taken_in),
    .upd_target_i (jump_addr_in)
  );

  always_comb begin
    // NOTE: pc_d gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    pc_d = pc_q;
    if (modify_pc_in) begin
      pc_d = {update_pc_in[31:2], 2'b00};
    end else if (!en) begin
      pc_d = pc_q;
    end else if (pred_taken_if) begin
      pc_d = pred_target_if;
    end else begin
      pc_d = pc_q + XLEN'(PC_STEP);  // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_if       = pc_q;
  assign flush_front = modify_pc_in;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a stimulus process drives one cycle
// at a time, asks a behavioural model what the DUT should show during that
// cycle and queues it; a monitor pops and compares on every falling edge.
module tb_fetch_pc_unit;

  localparam int          ENTRIES  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, en, modify_pc_in, update_btb_in, upd_taken_in;
  logic [31:0] update_pc_in, jump_addr_in, upd_src_pc_in;
  logic [31:0] pc_if, pred_target_if;
  logic        pred_taken_if, flush_front;

  fetch_pc_unit #(
    .RESET_PC    (RESET_PC),
    .BTB_ENTRIES (ENTRIES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .modify_pc_in   (modify_pc_in),
    .update_pc_in   (update_pc_in),
    .jump_addr_in   (jump_addr_in),
    .update_btb_in  (update_btb_in),
    .upd_src_pc_in  (upd_src_pc_in),
    .upd_taken_in   (upd_taken_in),
    .pc_if          (pc_if),
    .pred_taken_if  (pred_taken_if),
    .pred_target_if (pred_target_if),
    .flush_front    (flush_front)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic        fl;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // ---------------- reference model ----------------
  // Each slot remembers the full PC of the branch that owns it; two PCs
  // conflict when they fall in the same slot but different table "lines".
  bit          m_valid [ENTRIES];
  logic [31:0] m_src   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_pc;
  bit          m_known = 0;

  function automatic int unsigned slot(input logic [31:0] a);
    return (a / 4) % ENTRIES;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a / (4 * ENTRIES);
  endfunction

  function automatic bit owns(input int unsigned i, input logic [31:0] a);
    return m_valid[i] && (line_of(m_src[i]) == line_of(a));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit mod, input logic [31:0] upc,
                      input bit ub, input logic [31:0] src, input bit tk,
                      input logic [31:0] ja);
    exp_t        x;
    int unsigned i;
    bit          pt;
    logic [31:0] ptgt;
    @(posedge clk);
    #1;
    rst = r; en = e; modify_pc_in = mod; update_pc_in = upc;
    update_btb_in = ub; upd_src_pc_in = src; upd_taken_in = tk; jump_addr_in = ja;

    pt = 0; ptgt = '0;
    if (m_known) begin
      i    = slot(m_pc);
      pt   = owns(i, m_pc) && (m_ctr[i] >= 2);
      ptgt = pt ? m_tgt[i] : 32'h0;
      x.pc = m_pc; x.pt = pt; x.tgt = ptgt; x.fl = mod;
      sb_q.push_back(x);
    end

    if (r) begin
      m_pc = RESET_PC;
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0; m_src[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1;
      end
      m_known = 1;
    end else if (m_known) begin
      if (mod)       m_pc = upc & ~32'h3;
      else if (!e)   m_pc = m_pc;
      else if (pt)   m_pc = ptgt;
      else           m_pc = m_pc + 32'd4;
      if (ub) begin
        i = slot(src);
        if (owns(i, src)) begin
          if (tk) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = ja;
          end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (tk) begin
          m_valid[i] = 1; m_src[i] = src; m_tgt[i] = ja; m_ctr[i] = 2;
        end
      end
    end
  endtask

  task automatic idle(input bit e);
    step(0, e, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] a, input bit e);
    step(0, e, 1, a, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic train(input logic [31:0] src, input bit tk, input logic [31:0] ja);
    step(0, 0, 0, 32'h0, 1, src, tk, ja);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FF00 | ($urandom_range(0, 63) * 4);
    return $urandom_range(0, 127) * 4;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("pc_if",          pc_if,                 x.pc);
        check("pred_taken_if",  32'(pred_taken_if),    32'(x.pt));
        check("pred_target_if", pred_target_if,        x.tgt);
        check("flush_front",    32'(flush_front),      32'(x.fl));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; en = 0; modify_pc_in = 0; update_pc_in = '0; jump_addr_in = '0;
    update_btb_in = 0; upd_src_pc_in = '0; upd_taken_in = 0;

    // Reset, then free-running fetch 0,4,8,C
    repeat (2) step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (5) idle(1);

    // Stall, then redirect during stall (low bits dropped)
    repeat (3) idle(0);
    redir(32'h0000_0103, 0);
    repeat (2) idle(0);

    // Allocate 0x20 -> 0x80 and run through it
    train(32'h20, 1, 32'h80);
    redir(32'h18, 0);
    repeat (5) idle(1);

    // Saturate then decay to weakly not-taken: 0x20 falls through to 0x24
    repeat (3) train(32'h20, 1, 32'h80);
    repeat (2) train(32'h20, 0, 32'h0);
    redir(32'h20, 0);
    repeat (3) idle(1);
    train(32'h20, 0, 32'h0);
    repeat (2) train(32'h20, 1, 32'h80);

    // Conflict: 0x60 replaces 0x20 in the same slot
    train(32'h60, 1, 32'h200);
    redir(32'h20, 0);
    repeat (3) idle(1);
    redir(32'h60, 0);
    repeat (3) idle(1);

    // Same-cycle update of the slot being looked up: old prediction used
    redir(32'h60, 0);
    step(0, 1, 0, 32'h0, 1, 32'h20, 1, 32'h300);
    repeat (2) idle(1);
    redir(32'h20, 0);
    repeat (2) idle(1);

    // Wrap-around
    redir(32'hFFFF_FFFC, 0);
    repeat (3) idle(1);

    // Reset together with redirect and update
    step(1, 1, 1, 32'h40, 1, 32'h40, 1, 32'h500);
    repeat (2) idle(1);
    redir(32'h20, 0);
    repeat (2) idle(1);
    redir(32'h40, 0);
    repeat (2) idle(1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] src_r;
      src_r = rand_addr();
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 19) == 0,
           rand_addr() | 32'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0,
           src_r,
           $urandom_range(0, 2) != 0,
           rand_addr());
    end

    // Drain with a bounded wait
    for (int w = 0; w < 8 && sb_q.size() > 0; w++) @(negedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
